// File: rtl/bcd_seg7_scanner.sv
// rtl/bcd_seg7_scanner.sv - multiplexed BCD 7-segment scanner with frame snapshot, blanking and guard
module bcd_seg7_scanner #(
    parameter int DIGITS         = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int GUARD          = 2,
    parameter int SEG_ACTIVE_LOW = 1,
    parameter int AN_ACTIVE_LOW  = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [4*DIGITS-1:0]   bcd_in,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an
);

    localparam int   CNT_W   = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int   IDX_W   = $clog2(DIGITS);
    localparam logic SEG_INV = (SEG_ACTIVE_LOW != 0);
    localparam logic AN_INV  = (AN_ACTIVE_LOW != 0);

    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic [4*DIGITS-1:0] snap_bcd_q, snap_bcd_d;
    logic [DIGITS-1:0]   snap_dp_q, snap_dp_d;
    logic [6:0]          seg_q, seg_d;
    logic                dp_q, dp_d;
    logic [DIGITS-1:0]   an_q, an_d;

    logic                tick;
    logic                frame_end;
    logic                zero_run;
    logic [DIGITS-1:0]   lz_mask;
    logic [3:0]          cur_bcd;
    logic                cur_dp;
    logic                cur_blank;
    logic [6:0]          cur_seg;

    // Slot timing: prescaler, slot index and frame-boundary snapshot capture
    always_comb begin
        tick       = (cnt_q == CNT_W'(REFRESH_DIV - 1));
        frame_end  = tick && (idx_q == IDX_W'(DIGITS - 1));
        cnt_d      = tick ? '0 : cnt_q + 1'b1;
        idx_d      = idx_q;
        snap_bcd_d = snap_bcd_q;
        snap_dp_d  = snap_dp_q;
        if (tick) begin
            idx_d = frame_end ? '0 : idx_q + 1'b1;
        end
        if (frame_end) begin
            snap_bcd_d = bcd_in;
            snap_dp_d  = dp_in;
        end
    end

    // Select the current slot's digit and work out which digits are leading zeros
    always_comb begin
        zero_run  = 1'b1;
        lz_mask   = '0;
        cur_bcd   = '0;
        cur_dp    = 1'b0;
        cur_blank = 1'b0;
        // Walk from the most significant digit down; a digit is a leading zero
        // while every digit above it (and itself) is zero. Digit 0 always shows.
        for (int i = DIGITS - 1; i >= 0; i--) begin
            zero_run   = zero_run && (snap_bcd_q[4*i +: 4] == 4'd0);
            lz_mask[i] = zero_run && (i != 0);
        end
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_bcd   = snap_bcd_q[4*i +: 4];
                cur_dp    = snap_dp_q[i];
                cur_blank = lz_mask[i];
            end
        end
    end

    // Segment decode, blanking and guard-gated anode select feeding the output register
    always_comb begin
        case (cur_bcd)
            4'd0:    cur_seg = 7'h3F;
            4'd1:    cur_seg = 7'h06;
            4'd2:    cur_seg = 7'h5B;
            4'd3:    cur_seg = 7'h4F;
            4'd4:    cur_seg = 7'h66;
            4'd5:    cur_seg = 7'h6D;
            4'd6:    cur_seg = 7'h7D;
            4'd7:    cur_seg = 7'h07;
            4'd8:    cur_seg = 7'h7F;
            4'd9:    cur_seg = 7'h6F;
            default: cur_seg = 7'h40;
        endcase
        seg_d = cur_seg;
        dp_d  = cur_dp;
        if (blank_lz && cur_blank) begin
            seg_d = 7'h00;
            dp_d  = 1'b0;
        end
        // The guard keeps all anodes dark at slot start so the previous digit's
        // segments never ghost onto the next anode.
        an_d = '0;
        for (int i = 0; i < DIGITS; i++) begin
            an_d[i] = (cnt_q >= CNT_W'(GUARD)) && (idx_q == IDX_W'(i));
        end
    end

    // State and output registers with asynchronous active-low reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q      <= '0;
            idx_q      <= '0;
            snap_bcd_q <= '0;
            snap_dp_q  <= '0;
            seg_q      <= '0;
            dp_q       <= 1'b0;
            an_q       <= '0;
        end else begin
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            snap_bcd_q <= snap_bcd_d;
            snap_dp_q  <= snap_dp_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign seg = seg_q ^ {7{SEG_INV}};
    assign dp  = dp_q ^ SEG_INV;
    assign an  = an_q ^ {DIGITS{AN_INV}};

endmodule
